present_enc_core: RTL and testbench
===================================

# present_enc_core

Iterative PRESENT block-cipher encryption core: accepts a 64-bit plaintext and an 80-bit key, runs one full round per clock, and returns the 64-bit ciphertext with a done pulse. It sits directly downstream of the 4-bit `sub_byte` S-box and consumes it. Sixteen instances form the substitution layer, and one more substitutes the top key nibble in the key schedule.

## Interface
- `ROUNDS`, default 31: number of rounds before the final key addition. Legal range is 1..31. Standard PRESENT requires 31.
- `clk`  input  1: sole clock. All state updates on the rising edge.
- `rst`  input  1: reset. One clock; reset is synchronous and active-high.
- `start`  input  1: request encryption. Sampled only while `busy`=0.
- `plaintext`  input  64: captured on an accepted `start`.
- `key`  input  80 (128 with `PRESENT_KEY128_EN`): captured on an accepted `start`.
- `busy`  output  1: high while an encryption is in progress.
- `done`  output  1: one-cycle pulse when `ciphertext` becomes valid.
- `ciphertext`  output  64: result. Holds its value until the next `done`.

## Operation
- States:
  - IDLE: reset state.
  - RUN: executes rounds.
  - FIN: final key addition.
- Internal registers:
  - `st[63:0]`: cipher state.
  - `kr`: key register, same width as `key`.
  - `rnd[4:0]`: round counter.
- IDLE, `start`=1: `st`<=`plaintext`, `kr`<=`key`, `rnd`<=1, go to RUN.
- IDLE, `start`=0: no change.
- RUN, each cycle:
  - Round key is `kr[79:16]`.
  - `st` <= pLayer(sBoxLayer(`st` ^ round key)).
  - `kr` <= keyUpdate(`kr`, `rnd`).
  - `rnd`<=`rnd`+1.
  - If `rnd`==`ROUNDS`, go to FIN instead of incrementing.
- sBoxLayer: nibble j = `st[4j+3:4j]`, j=0..15, each passes through `sub_byte` independently.
- pLayer: bit i moves to position (16·i) mod 63 for i=0..62. Bit 63 stays at 63.
- keyUpdate (80-bit), applied in this order:
  1. Rotate left by 61.
  2. Replace `[79:76]` with S(`[79:76]`).
  3. XOR `[19:15]` with `rnd`.
- FIN, one cycle: `ciphertext`<=`st` ^ `kr[79:16]`, `done`<=1, go to IDLE.
- `start` asserted during RUN or FIN is ignored and is not queued.
- `start` asserted in the same cycle that FIN returns to IDLE is ignored. The first acceptable `start` is the cycle after `done`.
- `plaintext`/`key` changes after capture have no effect on the operation in progress.
- `rnd` is 5 bits and never wraps; its maximum value is 31.

## Timing
- Reset values: `busy`=0, `done`=0, `ciphertext`=0. Also `st`=0, `kr`=0, `rnd`=0, state=IDLE.
- `rst` mid-operation aborts immediately at the next edge: state returns to IDLE, and no `done` is generated.
- `rst` has priority over `start`.
- Let E0 be the edge that samples `start` in IDLE.
  - `busy` rises after E0.
  - Rounds 1..ROUNDS execute on edges E1..E_ROUNDS.
  - FIN executes on edge E_ROUNDS+1. `done`=1 and the new `ciphertext` appear after that edge, and `busy` falls on the same edge.
- Latency is `ROUNDS`+1 cycles from start acceptance to `done`; 32 cycles at the default.
- Throughput is one block per `ROUNDS`+2 cycles when `start` is held high.
- `done` is high for exactly one cycle per accepted `start`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `PRESENT_KEY128_EN`.
- Defined: `key`/`kr` are 128 bits, and the round key is `kr[127:64]`. keyUpdate, in this order:
  1. Rotate left by 61.
  2. `[127:124]`<=S(`[127:124]`) and `[123:120]`<=S(`[123:120]`), using two key-schedule S-box instances.
  3. XOR `[66:62]` with `rnd`.
- Undefined: the 80-bit key schedule described under Operation, with one key-schedule S-box.
- State path, handshake and timing are identical in both builds.

## Test plan
- 80-bit build, pt=0000000000000000, key=00000000000000000000 -> after 32 cycles, `done` pulse with `ciphertext`=5579C1387B228445.
- 80-bit build, pt=0, key=FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049. Then pt=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B. Then pt=all-F, key=all-F -> 3333DCD3213210D2.
- Back-to-back run with `start` held high -> 4 blocks finish with `done` pulses 33 cycles apart. Pulses in the `busy` window are ignored, and each result matches the reference model.
- `rst` asserted at round 10, then a new `start` -> no `done` from the aborted run; outputs are 0 during reset; the new result is correct at 32 cycles.
- `PRESENT_KEY128_EN` build, pt=0, key=0 -> `ciphertext`=96DB702A2E6900AF.
- Inputs toggled randomly while `busy` -> result unaffected, and `ciphertext` is stable between `done` pulses.

Source files
------------

// File: rtl/present_enc_core.sv
// Iterative PRESENT encryption core: one round per clock, final key addition in FIN.
// Build option: define PRESENT_KEY128_EN for the 128-bit key schedule (default is 80-bit).

module sub_byte (
   input  logic [3:0] nibble,
   output logic [3:0] sub_c
);
   // PRESENT 4-bit S-box
   always_comb begin
      sub_c = 4'h0;
      case (nibble)
         4'h0: sub_c = 4'hC;
         4'h1: sub_c = 4'h5;
         4'h2: sub_c = 4'h6;
         4'h3: sub_c = 4'hB;
         4'h4: sub_c = 4'h9;
         4'h5: sub_c = 4'h0;
         4'h6: sub_c = 4'hA;
         4'h7: sub_c = 4'hD;
         4'h8: sub_c = 4'h3;
         4'h9: sub_c = 4'hE;
         4'hA: sub_c = 4'hF;
         4'hB: sub_c = 4'h8;
         4'hC: sub_c = 4'h4;
         4'hD: sub_c = 4'h7;
         4'hE: sub_c = 4'h1;
         4'hF: sub_c = 4'h2;
         default: sub_c = 4'h0;
      endcase
   end
endmodule

module present_enc_core #(
   parameter int unsigned ROUNDS = 31,
`ifdef PRESENT_KEY128_EN
   localparam int unsigned KW = 128
`else
   localparam int unsigned KW = 80
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [63:0]   plaintext,
   input  logic [KW-1:0] key,
   output logic          busy,
   output logic          done,
   output logic [63:0]   ciphertext
);

   localparam int unsigned SW = 64;
   localparam int unsigned RW = 5;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t          state, state_n;
   logic [SW-1:0]   st, st_n;
   logic [KW-1:0]   kr, kr_n;
   logic [RW-1:0]   rnd, rnd_n;
   logic            busy_n, done_n;
   logic [SW-1:0]   ct_n;

   logic [SW-1:0]   rk, mix, sb, pl;
   logic [KW-1:0]   rot, kupd;

   assign rk  = kr[KW-1 -: SW];
   assign mix = st ^ rk;

   // substitution layer
   for (genvar j = 0; j < 16; j++) begin : g_sbox
      sub_byte u_sb (.nibble(mix[4*j +: 4]), .sub_c(sb[4*j +: 4]));
   end

   // bit i lands at (16*i) mod 63; bit 63 is fixed
   for (genvar i = 0; i < 64; i++) begin : g_perm
      assign pl[(i == 63) ? 63 : ((16 * i) % 63)] = sb[i];
   end

   assign rot = {kr[KW-62:0], kr[KW-1:KW-61]};

`ifdef PRESENT_KEY128_EN
   logic [3:0] ks_hi, ks_lo;
   sub_byte u_ks_hi (.nibble(rot[127:124]), .sub_c(ks_hi));
   sub_byte u_ks_lo (.nibble(rot[123:120]), .sub_c(ks_lo));

   always_comb begin
      kupd          = rot;
      kupd[127:124] = ks_hi;
      kupd[123:120] = ks_lo;
      kupd[66:62]   = rot[66:62] ^ rnd;
   end
`else
   logic [3:0] ks_hi;
   sub_byte u_ks_hi (.nibble(rot[79:76]), .sub_c(ks_hi));

   always_comb begin
      kupd        = rot;
      kupd[79:76] = ks_hi;
      kupd[19:15] = rot[19:15] ^ rnd;
   end
`endif

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         st         <= '0;
         kr         <= '0;
         rnd        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ciphertext <= '0;
      end else begin
         state      <= state_n;
         st         <= st_n;
         kr         <= kr_n;
         rnd        <= rnd_n;
         busy       <= busy_n;
         done       <= done_n;
         ciphertext <= ct_n;
      end
   end

   // next-state and next-output logic
   always_comb begin
      state_n = state;
      st_n    = st;
      kr_n    = kr;
      rnd_n   = rnd;
      busy_n  = busy;
      done_n  = 1'b0;
      ct_n    = ciphertext;
      case (state)
         IDLE: begin
            if (start) begin
               st_n    = plaintext;
               kr_n    = key;
               rnd_n   = RW'(1);
               busy_n  = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            st_n = pl;
            kr_n = kupd;
            // counter parks at ROUNDS so it never wraps
            if (rnd == RW'(ROUNDS)) begin
               state_n = FIN;
            end else begin
               rnd_n = rnd + RW'(1);
            end
         end
         FIN: begin
            ct_n    = mix;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_present_enc_core.sv
// Self-checking bench for present_enc_core against a loop-based PRESENT reference model.
// Honours PRESENT_KEY128_EN to match the DUT key width.

module tb_present_enc_core;

   localparam int unsigned ROUNDS = 31;
`ifdef PRESENT_KEY128_EN
   localparam int unsigned KW = 128;
`else
   localparam int unsigned KW = 80;
`endif
   localparam int unsigned PERIOD = ROUNDS + 2;
   localparam logic [63:0] SBOX_TAB = 64'h2174_8FE3_DA09_B65C;

   logic          clk;
   logic          rst;
   logic          start;
   logic [63:0]   plaintext;
   logic [KW-1:0] key;
   logic          busy;
   logic          done;
   logic [63:0]   ciphertext;

   int n_cmp;
   int n_err;
   logic [63:0] last_ct;

   present_enc_core #(.ROUNDS(ROUNDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .plaintext  (plaintext),
      .key        (key),
      .busy       (busy),
      .done       (done),
      .ciphertext (ciphertext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [63:0] tab;
      tab = SBOX_TAB;
      return tab[4*x +: 4];
   endfunction

   function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [KW-1:0] k);
      logic [63:0]   s, t, p;
      logic [KW-1:0] kk;
      int            pos;
      s  = pt;
      kk = k;
      for (int r = 1; r <= int'(ROUNDS); r++) begin
         s = s ^ kk[KW-1 -: 64];
         for (int j = 0; j < 16; j++) t[4*j +: 4] = sbox(s[4*j +: 4]);
         p = '0;
         for (int i = 0; i < 64; i++) begin
            pos = (i == 63) ? 63 : (i * 16) % 63;
            p[pos] = t[i];
         end
         s  = p;
         kk = (kk << 61) | (kk >> (KW - 61));
         kk[KW-1 -: 4] = sbox(kk[KW-1 -: 4]);
`ifdef PRESENT_KEY128_EN
         kk[KW-5 -: 4] = sbox(kk[KW-5 -: 4]);
         kk[66:62] = kk[66:62] ^ 5'(r);
`else
         kk[19:15] = kk[19:15] ^ 5'(r);
`endif
      end
      return s ^ kk[KW-1 -: 64];
   endfunction

   function automatic logic [KW-1:0] rand_key();
      return KW'({$urandom(), $urandom(), $urandom(), $urandom()});
   endfunction

   function automatic logic [63:0] rand_pt();
      return {$urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [63:0] pt, input logic [KW-1:0] k);
      plaintext = pt;
      key       = k;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(output int lat, output bit got);
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         lat++;
         if (done) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; plaintext = '0; key = '0;
      tick(); tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
      n_cmp++; if (ciphertext !== 64'h0) begin n_err++; $display("FAIL reset_ct: got %h expected 0", ciphertext); end
      rst = 1'b0;
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
      last_ct = 64'h0;
   endtask

   task automatic test_vectors();
      logic [63:0]   pts [4];
      logic [KW-1:0] keys[4];
      logic [63:0]   exps[4];
      int            lat;
      bit            got;
`ifdef PRESENT_KEY128_EN
      pts[0] = 64'h0; keys[0] = '0; exps[0] = 64'h96DB_702A_2E69_00AF;
      for (int v = 1; v < 4; v++) begin
         pts[v] = rand_pt(); keys[v] = rand_key(); exps[v] = ref_enc(pts[v], keys[v]);
      end
`else
      pts[0] = 64'h0;                   keys[0] = '0;       exps[0] = 64'h5579_C138_7B22_8445;
      pts[1] = 64'h0;                   keys[1] = '1;       exps[1] = 64'hE72C_46C0_F594_5049;
      pts[2] = 64'hFFFF_FFFF_FFFF_FFFF; keys[2] = '0;       exps[2] = 64'hA112_FFC7_2F68_417B;
      pts[3] = 64'hFFFF_FFFF_FFFF_FFFF; keys[3] = '1;       exps[3] = 64'h3333_DCD3_2132_10D2;
`endif
      for (int v = 0; v < 4; v++) begin
         launch(pts[v], keys[v]);
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL vec%0d_busy_rise: got %b expected 1", v, busy); end
         wait_done(lat, got);
         n_cmp++;
         if (!got) begin
            n_err++; $display("FAIL vec%0d_timeout: got no done expected done within 200 cycles", v);
            continue;
         end
         n_cmp++; if (lat != int'(ROUNDS) + 1) begin n_err++; $display("FAIL vec%0d_latency: got %0d expected %0d", v, lat, ROUNDS + 1); end
         n_cmp++; if (ciphertext !== exps[v]) begin n_err++; $display("FAIL vec%0d_ct: got %h expected %h", v, ciphertext, exps[v]); end
         n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL vec%0d_busy_fall: got %b expected 0", v, busy); end
         last_ct = exps[v];
         tick();
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL vec%0d_done_pulse: got %b expected 0", v, done); end
         n_cmp++; if (ciphertext !== last_ct) begin n_err++; $display("FAIL vec%0d_ct_hold: got %h expected %h", v, ciphertext, last_ct); end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] expq[$];
      int          ndone;
      int          last_c;
      logic [63:0] e;
      ndone  = 0;
      last_c = -1;
      start  = 1'b1;
      for (int c = 0; c < 4 * int'(PERIOD); c++) begin
         plaintext = rand_pt();
         key       = rand_key();
         if (c % int'(PERIOD) == 0) expq.push_back(ref_enc(plaintext, key));
         tick();
         if (done) begin
            ndone++;
            n_cmp++;
            if (c % int'(PERIOD) != int'(ROUNDS) + 1) begin
               n_err++; $display("FAIL b2b_done_phase: got cycle %0d expected phase %0d", c, ROUNDS + 1);
            end
            if (last_c >= 0) begin
               n_cmp++;
               if (c - last_c != int'(PERIOD)) begin
                  n_err++; $display("FAIL b2b_spacing: got %0d expected %0d", c - last_c, PERIOD);
               end
            end
            last_c = c;
            e = (expq.size() > 0) ? expq.pop_front() : 64'hx;
            n_cmp++; if (ciphertext !== e) begin n_err++; $display("FAIL b2b_ct: got %h expected %h", ciphertext, e); end
            last_ct = e;
         end
      end
      start = 1'b0;
      n_cmp++; if (ndone != 4) begin n_err++; $display("FAIL b2b_count: got %0d expected 4", ndone); end
      tick();
   endtask

   task automatic test_reset_abort();
      logic [63:0]   pt;
      logic [KW-1:0] k;
      int            lat;
      bit            got;
      int            spurious;
      launch(rand_pt(), rand_key());
      for (int i = 0; i < 9; i++) tick();
      rst = 1'b1;
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", done); end
      n_cmp++; if (ciphertext !== 64'h0) begin n_err++; $display("FAIL abort_ct: got %h expected 0", ciphertext); end
      rst = 1'b0;
      spurious = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done || busy) spurious++;
      end
      n_cmp++; if (spurious != 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles expected 0", spurious); end
      pt = rand_pt(); k = rand_key();
      launch(pt, k);
      wait_done(lat, got);
      n_cmp++;
      if (!got) begin
         n_err++; $display("FAIL abort_rerun_timeout: got no done expected done within 200 cycles");
      end else begin
         n_cmp++; if (lat != int'(ROUNDS) + 1) begin n_err++; $display("FAIL abort_rerun_latency: got %0d expected %0d", lat, ROUNDS + 1); end
         n_cmp++; if (ciphertext !== ref_enc(pt, k)) begin n_err++; $display("FAIL abort_rerun_ct: got %h expected %h", ciphertext, ref_enc(pt, k)); end
         last_ct = ref_enc(pt, k);
      end
      tick();
   endtask

   task automatic test_input_toggle();
      logic [63:0]   pt;
      logic [KW-1:0] k;
      bit            got;
      int            lat;
      int            unstable;
      for (int it = 0; it < 4; it++) begin
         pt = rand_pt(); k = rand_key();
         launch(pt, k);
         got = 1'b0; lat = 0; unstable = 0;
         for (int i = 0; i < 200; i++) begin
            plaintext = rand_pt();
            key       = rand_key();
            start     = 1'($urandom_range(0, 1));
            tick();
            lat++;
            if (done) begin
               got = 1'b1;
               break;
            end
            if (ciphertext !== last_ct) unstable++;
         end
         start = 1'b0;
         n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL toggle%0d_ct_stable: got %0d changed cycles expected 0", it, unstable); end
         n_cmp++;
         if (!got) begin
            n_err++; $display("FAIL toggle%0d_timeout: got no done expected done within 200 cycles", it);
            continue;
         end
         n_cmp++; if (lat != int'(ROUNDS) + 1) begin n_err++; $display("FAIL toggle%0d_latency: got %0d expected %0d", it, lat, ROUNDS + 1); end
         n_cmp++; if (ciphertext !== ref_enc(pt, k)) begin n_err++; $display("FAIL toggle%0d_ct: got %h expected %h", it, ciphertext, ref_enc(pt, k)); end
         last_ct = ref_enc(pt, k);
         tick();
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL toggle%0d_done_pulse: got %b expected 0", it, done); end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_vectors();
      test_back_to_back();
      test_reset_abort();
      test_input_toggle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
